pipe_skid_stage: RTL

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_pkg.sv | 6 +
 rtl/sat_counter.sv | 13 +
 rtl/pipe_skid_stage.sv | 68 ++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default widths for the pipeline skid stage
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    localparam int DATA_W_DEF = 96;
    localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        if (clr) q <= '0;
        else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer with registered in_ready, flush and stall/flush counters
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    state_t state;
    logic [DATA_W-1:0] main_q, skid_q;
    logic ready_q, in_xfer, out_xfer;
    assign in_ready = ready_q & ~flush;
    assign out_valid = state != EMPTY;
    assign out_data = main_q;
    assign occupancy = state;
    assign in_xfer = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    // ready_q mirrors (state != FULL) for the state being entered, so in_ready has no path from out_ready
    always_ff @(posedge clk)
        if (rst || flush) begin
            state <= EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
            ready_q <= 1'b1;
        end else
            case (state)
                EMPTY: if (in_xfer) begin
                    main_q <= in_data;
                    state <= ONE;
                end
                ONE: if (in_xfer && out_xfer) main_q <= in_data;
                else if (out_xfer) begin
                    main_q <= BUBBLE;
                    state <= EMPTY;
                end else if (in_xfer) begin
                    skid_q <= in_data;
                    state <= FULL;
                    ready_q <= 1'b0;
                end
                FULL: if (out_xfer) begin
                    main_q <= skid_q;
                    skid_q <= BUBBLE;
                    state <= ONE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state <= EMPTY;
                    main_q <= BUBBLE;
                    skid_q <= BUBBLE;
                    ready_q <= 1'b1;
                end
            endcase
    sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .clr(rst), .inc(out_valid & ~out_ready), .q(stall_cnt));
    sat_counter #(.W(CNT_W)) u_flush (.clk(clk), .clr(rst), .inc(flush), .q(flush_cnt));
endmodule
